// File: rtl/mult_hilo_ctrl.sv
// Multiply/HI-LO controller between the execute stage and an unsigned 32x32 multiplier.
// Latency: issue edge to HI/LO update is MIN_WAIT+2 cycles minimum; abort after TIMEOUT RUN cycles.
// Backpressure: busy stalls the pipeline from the op_valid cycle until the cycle after FIX.
module mult_hilo_ctrl #(
  parameter int MIN_WAIT = 2,   // RUN cycles during which mul_done is treated as stale
  parameter int TIMEOUT  = 32   // RUN cycles without an accepted done before abort; > MIN_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        mul_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        res_valid,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_WAIT);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          start_q, start_d;
  logic          err_q, err_d;

  // Two's complement magnitude; 0x80000000 maps to itself, which is right when read unsigned.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // State register: everything clears on reset, aborting any in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: issue and MTHI/MTLO in IDLE, wait for done in RUN, sign-fix in FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    start_d = start_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // A same-cycle write still lands; a started multiply overwrites it later.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (op_valid) begin
          mul_a_d = mag(op_a, op_signed);
          mul_b_d = mag(op_b, op_signed);
          neg_d   = op_signed & (op_a[31] ^ op_b[31]);
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // Early done is a leftover from the previous op, so it is only trusted from MIN_WAIT on.
        if (mul_done && (cnt_q >= MIN_C)) begin
          prod_d  = mul_z;
          start_d = 1'b0;
          state_d = S_FIX;
        end else if (cnt_q == LAST_C) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FIX: begin
        {hi_d, lo_d} = neg_q ? (~prod_q + 64'd1) : prod_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = ((state_q == S_IDLE) && op_valid) || (state_q != S_IDLE);
  assign res_valid = (state_q == S_FIX);
  assign mul_start = start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Randomized self-checking bench for mult_hilo_ctrl with an attached multiplier model.
// Reference results come from plain signed/unsigned 64-bit arithmetic on the operands.
// Timing expectations are expressed in cycles counted from the issue edge.
module tb_mult_hilo_ctrl;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_signed;
  logic [31:0] op_a, op_b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, mul_start;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic        mul_done;
  logic [31:0] hi, lo;
  logic        res_valid, err;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_err = 1'b0;

  mult_hilo_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_signed(op_signed), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_done(mul_done),
    .hi(hi), .lo(lo), .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'h0000_0002;
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // One multiply. delay<0: the multiplier never answers. Otherwise done (with the
  // true product) is raised from RUN cycle 'delay' on. stale: done held high with
  // junk before MIN_WAIT. noise: random MTHI/MTLO activity while busy.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int delay, input bit stale, input bit wr_issue, input bit noise);
    logic [31:0] ea, eb;
    logic [63:0] exp_p;
    longint      sa, sb;
    int          res_cnt, res_cyc, idle_cyc;
    bit          held_ok, stable_ok;
    res_cnt = 0; res_cyc = -1; idle_cyc = -1;
    held_ok = 1'b1; stable_ok = 1'b1;

    ea = (s && a[31]) ? (32'd0 - a) : a;
    eb = (s && b[31]) ? (32'd0 - b) : b;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      exp_p = 64'(sa * sb);
    end else begin
      exp_p = {32'd0, a} * {32'd0, b};
    end

    op_valid = 1'b1; op_signed = s; op_a = a; op_b = b;
    if (wr_issue) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      m_hi = wdata; m_lo = wdata;
    end
    if (stale) begin
      mul_done = 1'b1;
      mul_z    = {$urandom, $urandom};
    end
    #1;
    chk("busy_at_issue", 64'(busy), 64'd1);
    tick();
    op_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("mul_a", 64'(mul_a), 64'(ea));
    chk("mul_b", 64'(mul_b), 64'(eb));
    chk("mul_start_run", 64'(mul_start), 64'd1);
    chk("hilo_after_issue", {hi, lo}, {m_hi, m_lo});

    for (int c = 0; c < 80; c++) begin
      if (res_valid) begin
        res_cnt++;
        res_cyc = c;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      if (mul_a !== ea || mul_b !== eb) stable_ok = 1'b0;
      if (hi !== m_hi || lo !== m_lo) held_ok = 1'b0;
      if (delay >= 0 && c >= delay) begin
        mul_done = 1'b1;
        mul_z    = 64'(mul_a) * 64'(mul_b);
      end else if (!(stale && c < MIN_WAIT)) begin
        mul_done = 1'b0;
      end
      if (noise) begin
        hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      end
      tick();
    end
    hi_we = 1'b0; lo_we = 1'b0; mul_done = 1'b0;

    if (delay >= 0) begin
      m_hi = exp_p[63:32];
      m_lo = exp_p[31:0];
      chk("res_valid_count", 64'(res_cnt), 64'd1);
      chk("res_valid_cycle", 64'(res_cyc), 64'(delay + 1));
      chk("idle_cycle", 64'(idle_cyc), 64'(delay + 2));
    end else begin
      m_err = 1'b1;
      chk("res_valid_count", 64'(res_cnt), 64'd0);
      chk("timeout_cycle", 64'(idle_cyc), 64'(TIMEOUT));
    end
    chk("hilo_held_while_busy", 64'(held_ok), 64'd1);
    chk("operands_stable", 64'(stable_ok), 64'd1);
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("err", 64'(err), 64'(m_err));
    chk("mul_start_idle", 64'(mul_start), 64'd0);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mul_z = '0; mul_done = 1'b0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0; m_hi = 32'h1234_5678;
    chk("mthi", 64'(hi), 64'(m_hi));
    lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    tick();
    lo_we = 1'b0; m_lo = 32'h9ABC_DEF0;
    chk("mtlo", {hi, lo}, {m_hi, m_lo});

    // Directed multiplies
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, MIN_WAIT, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1000, MIN_WAIT, 1'b0, 1'b1, 1'b1);

    // Randomized multiplies
    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), pick_operand(), pick_operand(),
            $urandom_range(MIN_WAIT, 9), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Multiplier never answers, with MTHI/MTLO noise during RUN
    do_op(1'b1, 32'h0000_0003, 32'hFFFF_FFF0, -1, 1'b0, 1'b0, 1'b1);

    // Back-to-back op after a timeout still works and err stays sticky
    do_op(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 3, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'h0000_0010; op_b = 32'h0000_0020;
    tick();
    op_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    m_hi = '0; m_lo = '0; m_err = 1'b0;
    chk("rst_run_hi", 64'(hi), 64'd0);
    chk("rst_run_lo", 64'(lo), 64'd0);
    chk("rst_run_mul_start", 64'(mul_start), 64'd0);
    chk("rst_run_busy", 64'(busy), 64'd0);
    chk("rst_run_err", 64'(err), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_run_no_update", {hi, lo}, 64'd0);

    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 6, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
